// File: rtl/estagio_writeback.sv
// -----------------------------------------------------------------------------
// estagio_writeback
//
// Write-back stage that sits directly after execute. Each accepted instruction
// has its write-back value selected (ALU result, memory read data or PC+1) and
// is stored in a 2-entry skid buffer. The oldest entry (head) drives the
// register-file write port. The youngest writing entry drives a forwarding path
// back to execute.
//
// Optional feature: define CONTADOR_RETIRADAS_EN to add the 'retiradas' output.
// It is a wrapping 32-bit count of every entry that retires.
//
// Ports:
//   clock, reset         system clock (rising edge), synchronous active-high reset
//   ex_valid / ex_ready  handshake from execute (ex_ready is registered)
//   ex_saida_ula         ALU result
//   ex_saida_memoria     data-memory read data
//   ex_pc                instruction PC
//   ex_fonte_wb          0=ALU, 1=memory, 2=PC+1, 3=no write
//   ex_reg_destino       destination register index
//   ex_hab_escrita_reg   instruction writes a register
//   flush                discard the incoming instruction this cycle
//   wb_valid / wb_ready  handshake to the register-file write port
//   wb_dado, wb_reg_destino  write data and register index
//   fwd_valid, fwd_reg, fwd_dado  forwarding of the youngest pending write
//   retiradas            (CONTADOR_RETIRADAS_EN only) retire counter
// -----------------------------------------------------------------------------
module estagio_writeback #(
  parameter int LARGURA  = 32,
  parameter int BITS_REG = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [LARGURA-1:0]  ex_saida_ula,
  input  logic [LARGURA-1:0]  ex_saida_memoria,
  input  logic [LARGURA-1:0]  ex_pc,
  input  logic [1:0]          ex_fonte_wb,
  input  logic [BITS_REG-1:0] ex_reg_destino,
  input  logic                ex_hab_escrita_reg,
  input  logic                flush,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [LARGURA-1:0]  wb_dado,
  output logic [BITS_REG-1:0] wb_reg_destino,
  output logic                fwd_valid,
  output logic [BITS_REG-1:0] fwd_reg,
  output logic [LARGURA-1:0]  fwd_dado
`ifdef CONTADOR_RETIRADAS_EN
  ,
  output logic [31:0]         retiradas
`endif
);

  typedef enum logic [1:0] {
    FONTE_ULA     = 2'd0,
    FONTE_MEMORIA = 2'd1,
    FONTE_LINK    = 2'd2,
    FONTE_NENHUMA = 2'd3
  } fonte_wb_e;

  // Buffer state
  logic [1:0]          r_valid;
  logic [1:0]          r_escreve;
  logic [LARGURA-1:0]  r_dado [2];
  logic [BITS_REG-1:0] r_reg  [2];
  logic                r_rd_ptr;
  logic                r_wr_ptr;
  logic [1:0]          r_ocupacao;
  logic                r_ex_ready;

  // Registered outputs (computed from the next buffer state)
  logic                r_wb_valid;
  logic [LARGURA-1:0]  r_wb_dado;
  logic [BITS_REG-1:0] r_wb_reg;
  logic                r_fwd_valid;
  logic [BITS_REG-1:0] r_fwd_reg;
  logic [LARGURA-1:0]  r_fwd_dado;

  // Combinational signals
  logic                w_aceita;
  logic                w_retira;
  logic [LARGURA-1:0]  w_dado_novo;
  logic                w_escreve_novo;
  logic [1:0]          w_valid_prox;
  logic [1:0]          w_escreve_prox;
  logic [LARGURA-1:0]  w_dado_prox [2];
  logic [BITS_REG-1:0] w_reg_prox  [2];
  logic                w_rd_prox;
  logic                w_wr_prox;
  logic                w_jovem;
  logic [1:0]          w_ocupacao_prox;
  logic                w_wb_valid_prox;
  logic [LARGURA-1:0]  w_wb_dado_prox;
  logic [BITS_REG-1:0] w_wb_reg_prox;
  logic                w_fwd_valid_prox;
  logic [BITS_REG-1:0] w_fwd_reg_prox;
  logic [LARGURA-1:0]  w_fwd_dado_prox;

  assign w_aceita = ex_valid & r_ex_ready & ~flush;

  // A head that does not write leaves after one cycle at the head regardless
  // of wb_ready; a writing head leaves only when the register file takes it.
  assign w_retira = r_valid[r_rd_ptr] & (~r_escreve[r_rd_ptr] | wb_ready);

  // Write-back value selection. PC+1 wraps naturally at LARGURA bits.
  always_comb begin
    w_dado_novo = '0;
    unique case (fonte_wb_e'(ex_fonte_wb))
      FONTE_ULA:     w_dado_novo = ex_saida_ula;
      FONTE_MEMORIA: w_dado_novo = ex_saida_memoria;
      FONTE_LINK:    w_dado_novo = ex_pc + LARGURA'(1);
      FONTE_NENHUMA: w_dado_novo = '0;
    endcase
  end

  // Register 0 is hard-wired, so a write to it is turned into a no-op entry.
  assign w_escreve_novo = ex_hab_escrita_reg
                        & (ex_fonte_wb != FONTE_NENHUMA)
                        & (ex_reg_destino != '0);

  // Next buffer state. With one entry held, accept and retire target
  // different slots, so both updates can be applied in the same cycle.
  // NOTE: every variable gets a default at the top of the always_comb so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_valid_prox   = r_valid;
    w_escreve_prox = r_escreve;
    w_dado_prox    = r_dado;
    w_reg_prox     = r_reg;
    w_rd_prox      = r_rd_ptr;
    w_wr_prox      = r_wr_ptr;
    w_ocupacao_prox = r_ocupacao;

    if (w_retira) begin
      w_valid_prox[r_rd_ptr] = 1'b0;
      w_rd_prox              = ~r_rd_ptr;
    end
    if (w_aceita) begin
      w_valid_prox[r_wr_ptr]   = 1'b1;
      w_escreve_prox[r_wr_ptr] = w_escreve_novo;
      w_dado_prox[r_wr_ptr]    = w_dado_novo;
      w_reg_prox[r_wr_ptr]     = ex_reg_destino;
      w_wr_prox                = ~r_wr_ptr;
    end

    unique case ({w_aceita, w_retira})
      2'b10:   w_ocupacao_prox = r_ocupacao + 2'd1;
      2'b01:   w_ocupacao_prox = r_ocupacao - 2'd1;
      default: w_ocupacao_prox = r_ocupacao;
    endcase
  end

  // Output values for the next cycle. An empty buffer keeps the last data.
  // The youngest entry sits just behind the write pointer; the other slot is
  // the older one and is only consulted when the younger one does not write.
  always_comb begin
    w_wb_valid_prox = w_valid_prox[w_rd_prox] & w_escreve_prox[w_rd_prox];
    w_wb_dado_prox  = r_wb_dado;
    w_wb_reg_prox   = r_wb_reg;
    if (w_valid_prox[w_rd_prox]) begin
      w_wb_dado_prox = w_dado_prox[w_rd_prox];
      w_wb_reg_prox  = w_reg_prox[w_rd_prox];
    end

    w_jovem          = ~w_wr_prox;
    w_fwd_valid_prox = 1'b0;
    w_fwd_reg_prox   = r_fwd_reg;
    w_fwd_dado_prox  = r_fwd_dado;
    if (w_valid_prox[w_jovem] && w_escreve_prox[w_jovem]) begin
      w_fwd_valid_prox = 1'b1;
      w_fwd_reg_prox   = w_reg_prox[w_jovem];
      w_fwd_dado_prox  = w_dado_prox[w_jovem];
    end else if (w_valid_prox[~w_jovem] && w_escreve_prox[~w_jovem]) begin
      w_fwd_valid_prox = 1'b1;
      w_fwd_reg_prox   = w_reg_prox[~w_jovem];
      w_fwd_dado_prox  = w_dado_prox[~w_jovem];
    end
  end

  // Control and output registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid     <= '0;
      r_escreve   <= '0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_ocupacao  <= '0;
      r_ex_ready  <= 1'b1;
      r_wb_valid  <= 1'b0;
      r_wb_dado   <= '0;
      r_wb_reg    <= '0;
      r_fwd_valid <= 1'b0;
      r_fwd_reg   <= '0;
      r_fwd_dado  <= '0;
    end else begin
      r_valid     <= w_valid_prox;
      r_escreve   <= w_escreve_prox;
      r_rd_ptr    <= w_rd_prox;
      r_wr_ptr    <= w_wr_prox;
      r_ocupacao  <= w_ocupacao_prox;
      r_ex_ready  <= (w_ocupacao_prox < 2'd2);
      r_wb_valid  <= w_wb_valid_prox;
      r_wb_dado   <= w_wb_dado_prox;
      r_wb_reg    <= w_wb_reg_prox;
      r_fwd_valid <= w_fwd_valid_prox;
      r_fwd_reg   <= w_fwd_reg_prox;
      r_fwd_dado  <= w_fwd_dado_prox;
    end
  end

  // Entry payload storage.
  // NOTE: the payload is not reset; r_valid qualifies every read, so stale
  // contents are never observed and the storage needs no reset path.
  always_ff @(posedge clock) begin
    r_dado <= w_dado_prox;
    r_reg  <= w_reg_prox;
  end

  assign ex_ready       = r_ex_ready;
  assign wb_valid       = r_wb_valid;
  assign wb_dado        = r_wb_dado;
  assign wb_reg_destino = r_wb_reg;
  assign fwd_valid      = r_fwd_valid;
  assign fwd_reg        = r_fwd_reg;
  assign fwd_dado       = r_fwd_dado;

`ifdef CONTADOR_RETIRADAS_EN
  logic [31:0] r_retiradas;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_retiradas <= '0;
    end else if (w_retira) begin
      r_retiradas <= r_retiradas + 32'd1;
    end
  end

  assign retiradas = r_retiradas;
`endif

endmodule

// File: tb/tb_estagio_writeback.sv
// -----------------------------------------------------------------------------
// tb_estagio_writeback
//
// Directed test bench for estagio_writeback. Inputs change 1 time unit after
// a rising edge. Outputs are sampled at that same point, which is clear of
// the edge. Each scenario task makes its own comparisons against
// hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_estagio_writeback;

  localparam int LARGURA  = 32;
  localparam int BITS_REG = 5;

  logic                clock = 1'b0;
  logic                reset;
  logic                ex_valid;
  logic                ex_ready;
  logic [LARGURA-1:0]  ex_saida_ula;
  logic [LARGURA-1:0]  ex_saida_memoria;
  logic [LARGURA-1:0]  ex_pc;
  logic [1:0]          ex_fonte_wb;
  logic [BITS_REG-1:0] ex_reg_destino;
  logic                ex_hab_escrita_reg;
  logic                flush;
  logic                wb_valid;
  logic                wb_ready;
  logic [LARGURA-1:0]  wb_dado;
  logic [BITS_REG-1:0] wb_reg_destino;
  logic                fwd_valid;
  logic [BITS_REG-1:0] fwd_reg;
  logic [LARGURA-1:0]  fwd_dado;
`ifdef CONTADOR_RETIRADAS_EN
  logic [31:0]         retiradas;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  estagio_writeback #(.LARGURA(LARGURA), .BITS_REG(BITS_REG)) dut (
    .clock              (clock),
    .reset              (reset),
    .ex_valid           (ex_valid),
    .ex_ready           (ex_ready),
    .ex_saida_ula       (ex_saida_ula),
    .ex_saida_memoria   (ex_saida_memoria),
    .ex_pc              (ex_pc),
    .ex_fonte_wb        (ex_fonte_wb),
    .ex_reg_destino     (ex_reg_destino),
    .ex_hab_escrita_reg (ex_hab_escrita_reg),
    .flush              (flush),
    .wb_valid           (wb_valid),
    .wb_ready           (wb_ready),
    .wb_dado            (wb_dado),
    .wb_reg_destino     (wb_reg_destino),
    .fwd_valid          (fwd_valid),
    .fwd_reg            (fwd_reg),
    .fwd_dado           (fwd_dado)
`ifdef CONTADOR_RETIRADAS_EN
    ,
    .retiradas          (retiradas)
`endif
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [1:0] fonte, input logic [31:0] ula,
                      input logic [31:0] mem, input logic [31:0] pc,
                      input logic [4:0] rd, input logic hab);
    ex_valid           = 1'b1;
    ex_fonte_wb        = fonte;
    ex_saida_ula       = ula;
    ex_saida_memoria   = mem;
    ex_pc              = pc;
    ex_reg_destino     = rd;
    ex_hab_escrita_reg = hab;
  endtask

  task automatic idle();
    ex_valid           = 1'b0;
    ex_fonte_wb        = 2'd0;
    ex_saida_ula       = '0;
    ex_saida_memoria   = '0;
    ex_pc              = '0;
    ex_reg_destino     = '0;
    ex_hab_escrita_reg = 1'b0;
    flush              = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    wb_ready = 1'b1;
    do_reset();
    n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %0b expected 0", wb_valid); end
    n_tests++; if (wb_dado !== 32'h0) begin n_fail++; $display("FAIL reset_wb_dado: got %h expected 00000000", wb_dado); end
    n_tests++; if (wb_reg_destino !== 5'd0) begin n_fail++; $display("FAIL reset_wb_reg: got %0d expected 0", wb_reg_destino); end
    n_tests++; if (fwd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_valid: got %0b expected 0", fwd_valid); end
    n_tests++; if (fwd_reg !== 5'd0 || fwd_dado !== 32'h0) begin n_fail++; $display("FAIL reset_fwd: got reg %0d dado %h expected 0/0", fwd_reg, fwd_dado); end
    n_tests++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ex_ready: got %0b expected 1", ex_ready); end
  endtask

  task automatic test_basic();
    wb_ready = 1'b1;
    push(2'd0, 32'h0000_002A, 32'h0, 32'h0, 5'd3, 1'b1);
    step();
    idle();
    n_tests++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL basic_wb_valid: got %0b expected 1", wb_valid); end
    n_tests++; if (wb_dado !== 32'h2A || wb_reg_destino !== 5'd3) begin n_fail++; $display("FAIL basic_wb: got %h/%0d expected 0000002a/3", wb_dado, wb_reg_destino); end
    n_tests++; if (fwd_valid !== 1'b1 || fwd_reg !== 5'd3 || fwd_dado !== 32'h2A) begin n_fail++; $display("FAIL basic_fwd: got %0b/%0d/%h expected 1/3/0000002a", fwd_valid, fwd_reg, fwd_dado); end
    step();
    n_tests++; if (wb_valid !== 1'b0 || fwd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got wb_valid %0b fwd_valid %0b expected 0/0", wb_valid, fwd_valid); end
    n_tests++; if (wb_dado !== 32'h2A || wb_reg_destino !== 5'd3) begin n_fail++; $display("FAIL basic_hold: got %h/%0d expected 0000002a/3", wb_dado, wb_reg_destino); end
  endtask

  task automatic test_stall_full();
    wb_ready = 1'b0;
    push(2'd1, 32'h0, 32'h0000_0011, 32'h0, 5'd4, 1'b1);
    step();
    n_tests++; if (ex_ready !== 1'b1 || wb_valid !== 1'b1 || wb_dado !== 32'h11) begin n_fail++; $display("FAIL stall_first: got ready %0b valid %0b dado %h expected 1/1/00000011", ex_ready, wb_valid, wb_dado); end
    push(2'd2, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'd31, 1'b1);
    step();
    n_tests++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full_ready: got %0b expected 0", ex_ready); end
    n_tests++; if (fwd_valid !== 1'b1 || fwd_reg !== 5'd31 || fwd_dado !== 32'h0) begin n_fail++; $display("FAIL stall_fwd_young: got %0b/%0d/%h expected 1/31/00000000", fwd_valid, fwd_reg, fwd_dado); end
    push(2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd7, 1'b1);
    step();
    idle();
    n_tests++; if (ex_ready !== 1'b0 || wb_valid !== 1'b1 || wb_dado !== 32'h11 || wb_reg_destino !== 5'd4) begin n_fail++; $display("FAIL stall_hold: got ready %0b valid %0b dado %h reg %0d expected 0/1/00000011/4", ex_ready, wb_valid, wb_dado, wb_reg_destino); end
    n_tests++; if (fwd_reg !== 5'd31 || fwd_dado !== 32'h0) begin n_fail++; $display("FAIL stall_third_ignored: got fwd %0d/%h expected 31/00000000", fwd_reg, fwd_dado); end
    wb_ready = 1'b1;
    step();
    n_tests++; if (wb_valid !== 1'b1 || wb_dado !== 32'h0 || wb_reg_destino !== 5'd31 || ex_ready !== 1'b1) begin n_fail++; $display("FAIL stall_second_out: got valid %0b dado %h reg %0d ready %0b expected 1/00000000/31/1", wb_valid, wb_dado, wb_reg_destino, ex_ready); end
    step();
    n_tests++; if (wb_valid !== 1'b0 || fwd_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drained: got wb_valid %0b fwd_valid %0b expected 0/0", wb_valid, fwd_valid); end
  endtask

  task automatic test_reg_zero();
    wb_ready = 1'b0;
    push(2'd0, 32'h0000_0055, 32'h0, 32'h0, 5'd0, 1'b1);
    step();
    n_tests++; if (wb_valid !== 1'b0 || fwd_valid !== 1'b0) begin n_fail++; $display("FAIL reg0_no_write: got wb_valid %0b fwd_valid %0b expected 0/0", wb_valid, fwd_valid); end
    push(2'd0, 32'h0000_0088, 32'h0, 32'h0, 5'd8, 1'b1);
    step();
    idle();
    // The reg-0 entry left on its own while wb_ready stayed low.
    n_tests++; if (ex_ready !== 1'b1 || wb_valid !== 1'b1 || wb_reg_destino !== 5'd8 || wb_dado !== 32'h88) begin n_fail++; $display("FAIL reg0_retired: got ready %0b valid %0b reg %0d dado %h expected 1/1/8/00000088", ex_ready, wb_valid, wb_reg_destino, wb_dado); end
    wb_ready = 1'b1;
    step();
    n_tests++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin n_fail++; $display("FAIL reg0_drained: got valid %0b ready %0b expected 0/1", wb_valid, ex_ready); end
  endtask

  task automatic test_flush();
    wb_ready = 1'b0;
    push(2'd0, 32'h0000_0099, 32'h0, 32'h0, 5'd6, 1'b1);
    step();
    push(2'd0, 32'h0000_0077, 32'h0, 32'h0, 5'd5, 1'b1);
    flush = 1'b1;
    step();
    idle();
    n_tests++; if (ex_ready !== 1'b1 || fwd_reg !== 5'd6 || fwd_dado !== 32'h99) begin n_fail++; $display("FAIL flush_dropped: got ready %0b fwd %0d/%h expected 1/6/00000099", ex_ready, fwd_reg, fwd_dado); end
    n_tests++; if (wb_valid !== 1'b1 || wb_reg_destino !== 5'd6 || wb_dado !== 32'h99) begin n_fail++; $display("FAIL flush_kept: got %0b/%0d/%h expected 1/6/00000099", wb_valid, wb_reg_destino, wb_dado); end
    wb_ready = 1'b1;
    step();
    step();
    n_tests++; if (wb_valid !== 1'b0 || wb_dado !== 32'h99) begin n_fail++; $display("FAIL flush_never_77: got valid %0b dado %h expected 0/00000099", wb_valid, wb_dado); end
  endtask

  task automatic test_fwd_priority();
    wb_ready = 1'b0;
    push(2'd0, 32'h0000_00A1, 32'h0, 32'h0, 5'd10, 1'b1);
    step();
    push(2'd3, 32'h1234_5678, 32'h0, 32'h0, 5'd11, 1'b1);
    step();
    idle();
    n_tests++; if (fwd_valid !== 1'b1 || fwd_reg !== 5'd10 || fwd_dado !== 32'hA1) begin n_fail++; $display("FAIL fwd_skip_nowrite: got %0b/%0d/%h expected 1/10/000000a1", fwd_valid, fwd_reg, fwd_dado); end
    wb_ready = 1'b1;
    step();
    n_tests++; if (wb_valid !== 1'b0 || fwd_valid !== 1'b0 || wb_dado !== 32'h0 || wb_reg_destino !== 5'd11) begin n_fail++; $display("FAIL fonte3_head: got valid %0b fwd %0b dado %h reg %0d expected 0/0/00000000/11", wb_valid, fwd_valid, wb_dado, wb_reg_destino); end
    step();
    wb_ready = 1'b0;
    push(2'd0, 32'h0000_00A1, 32'h0, 32'h0, 5'd10, 1'b1);
    step();
    push(2'd1, 32'h0, 32'h0000_00B2, 32'h0, 5'd10, 1'b1);
    step();
    idle();
    n_tests++; if (fwd_valid !== 1'b1 || fwd_reg !== 5'd10 || fwd_dado !== 32'hB2) begin n_fail++; $display("FAIL fwd_same_reg: got %0b/%0d/%h expected 1/10/000000b2", fwd_valid, fwd_reg, fwd_dado); end
    n_tests++; if (wb_dado !== 32'hA1) begin n_fail++; $display("FAIL fwd_same_head: got %h expected 000000a1", wb_dado); end
    wb_ready = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset_stalled();
    wb_ready = 1'b0;
    push(2'd0, 32'h0000_0123, 32'h0, 32'h0, 5'd9, 1'b1);
    step();
    idle();
    n_tests++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL rst_stall_pre: got %0b expected 1", wb_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++; if (wb_valid !== 1'b0 || fwd_valid !== 1'b0 || ex_ready !== 1'b1 || wb_dado !== 32'h0) begin n_fail++; $display("FAIL rst_stall_post: got valid %0b fwd %0b ready %0b dado %h expected 0/0/1/00000000", wb_valid, fwd_valid, ex_ready, wb_dado); end
    wb_ready = 1'b1;
    step();
    n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stall_dropped: got %0b expected 0", wb_valid); end
  endtask

`ifdef CONTADOR_RETIRADAS_EN
  task automatic test_contador();
    wb_ready = 1'b1;
    do_reset();
    n_tests++; if (retiradas !== 32'd0) begin n_fail++; $display("FAIL cnt_reset: got %0d expected 0", retiradas); end
    push(2'd0, 32'h1, 32'h0, 32'h0, 5'd1, 1'b1);
    step();
    push(2'd3, 32'h2, 32'h0, 32'h0, 5'd2, 1'b1);
    step();
    push(2'd1, 32'h0, 32'h3, 32'h0, 5'd3, 1'b1);
    step();
    idle();
    step();
    step();
    n_tests++; if (retiradas !== 32'd3) begin n_fail++; $display("FAIL cnt_three: got %0d expected 3", retiradas); end
    push(2'd0, 32'h4, 32'h0, 32'h0, 5'd4, 1'b1);
    flush = 1'b1;
    step();
    idle();
    step();
    step();
    n_tests++; if (retiradas !== 32'd3) begin n_fail++; $display("FAIL cnt_flush: got %0d expected 3", retiradas); end
  endtask
`endif

  initial begin
    reset    = 1'b1;
    wb_ready = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_stall_full();
    test_reg_zero();
    test_flush();
    test_fwd_priority();
    test_reset_stalled();
`ifdef CONTADOR_RETIRADAS_EN
    test_contador();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
